pos_to_data: RTL and testbench
==============================

# pos_to_data

Bitmap writer for the drawing path: accepts pen samples (x, y, down) from the plotter/touch side and sets the matching pixel in the flash-resident 1-bpp bitmap. Each write is a read-modify-write through a one-word write-back cache. The block sits between the position producer and the flash controller. It produces the same row-major, 24-words-per-line, MSB-leftmost layout that the flash-to-position reader consumes.

## Interface
Parameters:
- BASE_ADDR, 20'd0, flash word address of pixel (0,0)
- WIDTH, 384, pixels per line; fixed at 24 words × 16
- HEIGHT, 288, number of lines

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- iCLK  in  1  system clock
- iRST  in  1  asynchronous active-low reset
- iStart  in  1  pulse; arms the block, clears the cache and the drop counter
- iFlush  in  1  pulse; write back the dirty cache word, then pulse oFinish
- oBusy  out  1  high from iStart until the flush completes
- oFinish  out  1  one-cycle pulse when the flush completes
- iPOS_VALID  in  1  a sample is presented; held until acknowledged
- iX  in  9  pixel column
- iY  in  9  pixel row
- iDown  in  1  1 = pen down (set pixel); 0 = move only
- oPOS_ACK  out  1  one-cycle pulse; the sample is consumed
- oREAD_REQUEST  out  1  one-cycle pulse; read o_addr
- iDATA_FROM_FLASH  in  16  read data
- iDATA_READY  in  1  one-cycle pulse; read data is valid
- oWRITE_REQUEST  out  1  one-cycle pulse; write oDATA_TO_FLASH to o_addr
- oDATA_TO_FLASH  out  16  write data
- iWrite_Done  in  1  one-cycle pulse; the write has completed
- o_addr  out  20  flash word address
- oDropped  out  16  count of out-of-range pen-down samples since iStart; saturates at 16'hFFFF

## Operation
- Address: word = BASE_ADDR + iY*24 + iX[8:4]. Compute iY*24 as (iY<<4)+(iY<<3) at 14 bits, then zero-extend to 20 bits. Bit index = 15 − iX[3:0].
- Cache holds: c_valid, c_dirty, c_addr[19:0], c_data[15:0].
- FSM states: IDLE, ACCEPT, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, MERGE, FLUSH_REQ, FLUSH_WAIT.
- IDLE:
  - Waits for iStart. On iStart: c_valid=0, c_dirty=0, oDropped=0, oBusy=1, go to ACCEPT.
  - iPOS_VALID is ignored while in IDLE (no ack).
- ACCEPT (iPOS_VALID high and no flush pending):
  - iDown=0 → ack, no flash access.
  - iX≥WIDTH or iY≥HEIGHT with iDown=1 → ack, increment oDropped.
  - In range and c_valid and word==c_addr → c_data[bit]=1, c_dirty=1, ack.
  - Miss with c_dirty → WB_REQ. Miss with a clean or invalid cache → RD_REQ.
- WB_REQ: pulse oWRITE_REQUEST with o_addr=c_addr and data=c_data. Go to WB_WAIT. On iWrite_Done → RD_REQ.
- RD_REQ: latch the word address, pulse oREAD_REQUEST. Go to RD_WAIT. On iDATA_READY: c_data=iDATA_FROM_FLASH, c_addr=word, c_valid=1. Go to MERGE.
- MERGE: set the pixel bit, c_dirty=1, ack, return to ACCEPT.
- Flush:
  - iFlush in ACCEPT or IDLE is taken immediately.
  - iFlush in any other state is latched and taken on return to ACCEPT, before any new sample.
  - If c_dirty → FLUSH_REQ/FLUSH_WAIT (same write handshake), then c_dirty=0.
  - Then pulse oFinish, oBusy=0, go to IDLE. The cache stays valid.
- Simultaneous iFlush and iPOS_VALID in ACCEPT: the flush wins; the sample stays pending and is not acked.
- Reset mid-operation: all state is cleared and any dirty data is lost. The flash controller must tolerate an abandoned request.

## Timing
- Reset values: oBusy=0, oFinish=0, oPOS_ACK=0, oREAD_REQUEST=0, oWRITE_REQUEST=0, oDATA_TO_FLASH=0, o_addr=0, oDropped=0; FSM in IDLE.
- Cache hit, pen-up sample, or dropped sample: oPOS_ACK is asserted the cycle after iPOS_VALID is first sampled high in ACCEPT (1-cycle latency).
- Miss, clean cache: 3 cycles + read latency.
- Miss, dirty cache: 5 cycles + write latency + read latency.
- At most one flash request is outstanding at a time.
- Request pulses are exactly one cycle. o_addr and oDATA_TO_FLASH hold stable until the matching iDATA_READY or iWrite_Done.
- iDATA_READY or iWrite_Done arriving outside the matching wait state is ignored.
- The producer drops iPOS_VALID or changes the sample only after oPOS_ACK.

## Structure
- Package pos_data_pkg contains: WORDS_PER_LINE=24, the pos_state_t enum, and the address function word_addr(base, x, y).
- One sub-module, pix_addr_calc: combinational word address and bit mask from (iX, iY). It also produces the range flag.

## Test plan
- Reset, then iStart, then pen-down (0,0). Read returns 16'h0000 → write-back on flush of addr 0 with data 16'h8000; oFinish pulses.
- Pen-down (17,1) then (31,1). Expect one read of addr 25, no intermediate write; flush writes 16'h4001.
- Pen-down (0,0), then (0,1). Expect write of 16'h8000 to addr 0 before the read of addr 24.
- Pen-down (384,5) and (3,288). Expect both acked, oDropped=2, no flash traffic.
- Pen-up samples only. Expect each acked in 1 cycle, no requests; flush gives oFinish with no write.
- iFlush asserted during RD_WAIT. Expect the read to complete and the merge to be acked, then the write-back, then oFinish. Assert iRST mid-WB_WAIT: all outputs return to reset values.

Source files
------------

// File: rtl/pos_data_pkg.sv
// pos_data_pkg: shared definitions for the pen-sample bitmap writer.
//   WORDS_PER_LINE : 16-bit flash words per bitmap line (384 px / 16)
//   pos_state_t    : controller state encoding
//   word_addr()    : flash word address of pixel (x, y) in the row-major bitmap
package pos_data_pkg;

  localparam int WORDS_PER_LINE = 24;

  typedef enum logic [3:0] {
    IDLE,
    ACCEPT,
    WB_REQ,
    WB_WAIT,
    RD_REQ,
    RD_WAIT,
    MERGE,
    FLUSH_REQ,
    FLUSH_WAIT
  } pos_state_t;

  // y*24 is built from two shifts at 14 bits (511*24 still fits), then
  // zero-extended so the base add never sees sign or carry surprises.
  function automatic logic [19:0] word_addr(input logic [19:0] base,
                                            input logic [8:0]  x,
                                            input logic [8:0]  y);
    logic [13:0] y14;
    logic [13:0] lineOff;
    y14     = {5'd0, y};
    lineOff = (y14 << 4) + (y14 << 3);
    return base + {6'd0, lineOff} + {15'd0, x[8:4]};
  endfunction

endpackage

// File: rtl/pix_addr_calc.sv
// pix_addr_calc: combinational pixel-to-flash mapping.
//   iX, iY     : pixel column / row
//   wordAddr   : flash word holding the pixel
//   bitMask    : one-hot mask of the pixel inside that word (MSB = leftmost)
//   inRange    : pixel lies inside the WIDTH x HEIGHT bitmap
module pix_addr_calc
  import pos_data_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR = 20'd0,
  parameter int          WIDTH     = 384,
  parameter int          HEIGHT    = 288
) (
  input  logic [8:0]  iX,
  input  logic [8:0]  iY,
  output logic [19:0] wordAddr,
  output logic [15:0] bitMask,
  output logic        inRange
);

  assign wordAddr = word_addr(BASE_ADDR, iX, iY);
  assign bitMask  = 16'h8000 >> iX[3:0];
  assign inRange  = (32'(iX) < WIDTH) && (32'(iY) < HEIGHT);

endmodule

// File: rtl/pos_to_data.sv
// pos_to_data: sets pixels of the flash-resident 1-bpp bitmap from pen
// samples, using a one-word write-back cache (read-modify-write).
//   iCLK, iRST          : clock, asynchronous active-low reset
//   iStart / iFlush     : arm (clears cache + drop count) / write back and finish
//   oBusy / oFinish     : armed indicator / one-cycle flush-complete pulse
//   iPOS_VALID, iX, iY, iDown, oPOS_ACK : pen sample handshake
//   oREAD_REQUEST, iDATA_FROM_FLASH, iDATA_READY : flash read handshake
//   oWRITE_REQUEST, oDATA_TO_FLASH, iWrite_Done  : flash write handshake
//   o_addr              : flash word address of the current request
//   oDropped            : saturating count of out-of-range pen-down samples
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | disarmed; waits for iStart (a flush here finishes at once)
// ACCEPT     | armed; takes a pending flush first, else the next sample
// WB_REQ     | issue write-back of the dirty cache word
// WB_WAIT    | wait for iWrite_Done, then fetch the new word
// RD_REQ     | latch target word, issue read
// RD_WAIT    | wait for iDATA_READY, fill cache
// MERGE      | set pixel in cache, mark dirty, ack sample
// FLUSH_REQ  | issue write of dirty cache word for a flush
// FLUSH_WAIT | wait for iWrite_Done, then pulse oFinish and disarm
module pos_to_data
  import pos_data_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR = 20'd0,
  parameter int          WIDTH     = 384,
  parameter int          HEIGHT    = 288
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iFlush,
  output logic        oBusy,
  output logic        oFinish,
  input  logic        iPOS_VALID,
  input  logic [8:0]  iX,
  input  logic [8:0]  iY,
  input  logic        iDown,
  output logic        oPOS_ACK,
  output logic        oREAD_REQUEST,
  input  logic [15:0] iDATA_FROM_FLASH,
  input  logic        iDATA_READY,
  output logic        oWRITE_REQUEST,
  output logic [15:0] oDATA_TO_FLASH,
  input  logic        iWrite_Done,
  output logic [19:0] o_addr,
  output logic [15:0] oDropped
);

  pos_state_t  state;
  logic        cValid;
  logic        cDirty;
  logic [19:0] cAddr;
  logic [15:0] cData;
  logic [19:0] rdAddr;
  logic [15:0] rdMask;
  logic        flushPending;

  logic [19:0] wordAddr;
  logic [15:0] bitMask;
  logic        inRange;

  pix_addr_calc #(
    .BASE_ADDR (BASE_ADDR),
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT)
  ) uAddr (
    .iX       (iX),
    .iY       (iY),
    .wordAddr (wordAddr),
    .bitMask  (bitMask),
    .inRange  (inRange)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state          <= IDLE;
      cValid         <= 1'b0;
      cDirty         <= 1'b0;
      cAddr          <= '0;
      cData          <= '0;
      rdAddr         <= '0;
      rdMask         <= '0;
      flushPending   <= 1'b0;
      oBusy          <= 1'b0;
      oFinish        <= 1'b0;
      oPOS_ACK       <= 1'b0;
      oREAD_REQUEST  <= 1'b0;
      oWRITE_REQUEST <= 1'b0;
      oDATA_TO_FLASH <= '0;
      o_addr         <= '0;
      oDropped       <= '0;
    end else begin
      oFinish        <= 1'b0;
      oPOS_ACK       <= 1'b0;
      oREAD_REQUEST  <= 1'b0;
      oWRITE_REQUEST <= 1'b0;

      // A flush that arrives mid-transaction is remembered and served on
      // the way back to ACCEPT, ahead of any new sample.
      if (iFlush && (state inside {WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, MERGE}))
        flushPending <= 1'b1;

      case (state)
        IDLE: begin
          if (iStart) begin
            cValid       <= 1'b0;
            cDirty       <= 1'b0;
            oDropped     <= '0;
            flushPending <= 1'b0;
            oBusy        <= 1'b1;
            state        <= ACCEPT;
          end else if (iFlush) begin
            if (cDirty) begin
              oBusy <= 1'b1;
              state <= FLUSH_REQ;
            end else begin
              oFinish <= 1'b1;
            end
          end
        end

        ACCEPT: begin
          if (iFlush || flushPending) begin
            flushPending <= 1'b0;
            if (cDirty) begin
              state <= FLUSH_REQ;
            end else begin
              oFinish <= 1'b1;
              oBusy   <= 1'b0;
              state   <= IDLE;
            end
          // While our own ack is still visible the producer has not yet
          // replaced the sample, so the one on the bus is already consumed.
          end else if (iPOS_VALID && !oPOS_ACK) begin
            if (!iDown) begin
              oPOS_ACK <= 1'b1;
            end else if (!inRange) begin
              oPOS_ACK <= 1'b1;
              if (oDropped != 16'hFFFF)
                oDropped <= oDropped + 16'd1;
            end else if (cValid && (wordAddr == cAddr)) begin
              cData    <= cData | bitMask;
              cDirty   <= 1'b1;
              oPOS_ACK <= 1'b1;
            end else if (cDirty) begin
              state <= WB_REQ;
            end else begin
              state <= RD_REQ;
            end
          end
        end

        WB_REQ: begin
          oWRITE_REQUEST <= 1'b1;
          o_addr         <= cAddr;
          oDATA_TO_FLASH <= cData;
          state          <= WB_WAIT;
        end

        WB_WAIT: begin
          if (iWrite_Done) begin
            cDirty <= 1'b0;
            state  <= RD_REQ;
          end
        end

        RD_REQ: begin
          rdAddr        <= wordAddr;
          rdMask        <= bitMask;
          o_addr        <= wordAddr;
          oREAD_REQUEST <= 1'b1;
          state         <= RD_WAIT;
        end

        RD_WAIT: begin
          if (iDATA_READY) begin
            cData  <= iDATA_FROM_FLASH;
            cAddr  <= rdAddr;
            cValid <= 1'b1;
            state  <= MERGE;
          end
        end

        MERGE: begin
          cData    <= cData | rdMask;
          cDirty   <= 1'b1;
          oPOS_ACK <= 1'b1;
          state    <= ACCEPT;
        end

        FLUSH_REQ: begin
          oWRITE_REQUEST <= 1'b1;
          o_addr         <= cAddr;
          oDATA_TO_FLASH <= cData;
          state          <= FLUSH_WAIT;
        end

        FLUSH_WAIT: begin
          if (iWrite_Done) begin
            cDirty  <= 1'b0;
            oFinish <= 1'b1;
            oBusy   <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_to_data.sv
// tb_pos_to_data: self-checking bench for pos_to_data with a behavioural
// flash model and a pixel-level reference bitmap.
module tb_pos_to_data;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iStart = 1'b0;
  logic        iFlush = 1'b0;
  logic        oBusy;
  logic        oFinish;
  logic        iPOS_VALID = 1'b0;
  logic [8:0]  iX = '0;
  logic [8:0]  iY = '0;
  logic        iDown = 1'b0;
  logic        oPOS_ACK;
  logic        oREAD_REQUEST;
  logic [15:0] iDATA_FROM_FLASH = '0;
  logic        iDATA_READY = 1'b0;
  logic        oWRITE_REQUEST;
  logic [15:0] oDATA_TO_FLASH;
  logic        iWrite_Done = 1'b0;
  logic [19:0] o_addr;
  logic [15:0] oDropped;

  always #5 iCLK = ~iCLK;

  pos_to_data dut (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iStart           (iStart),
    .iFlush           (iFlush),
    .oBusy            (oBusy),
    .oFinish          (oFinish),
    .iPOS_VALID       (iPOS_VALID),
    .iX               (iX),
    .iY               (iY),
    .iDown            (iDown),
    .oPOS_ACK         (oPOS_ACK),
    .oREAD_REQUEST    (oREAD_REQUEST),
    .iDATA_FROM_FLASH (iDATA_FROM_FLASH),
    .iDATA_READY      (iDATA_READY),
    .oWRITE_REQUEST   (oWRITE_REQUEST),
    .oDATA_TO_FLASH   (oDATA_TO_FLASH),
    .iWrite_Done      (iWrite_Done),
    .o_addr           (o_addr),
    .oDropped         (oDropped)
  );

  int tests = 0;
  int failed = 0;

  // ---------------- flash model ----------------
  logic [15:0] flashMem [0:8191] = '{default: 16'h0000};
  int          flashLat = 0;
  int          rdCnt = 0;
  int          wrCnt = 0;
  logic [19:0] pendRdAddr = '0;
  logic [19:0] pendWrAddr = '0;
  logic [15:0] pendWrData = '0;
  int          protoErr = 0;
  int          rdAddrLog[$];
  longint      rdTime[$];
  int          wrAddrLog[$];
  int          wrDataLog[$];
  longint      wrTime[$];

  always @(negedge iCLK) begin
    iDATA_READY = 1'b0;
    iWrite_Done = 1'b0;
    if (!iRST) begin
      rdCnt = 0;
      wrCnt = 0;
    end else begin
      if ((oREAD_REQUEST || oWRITE_REQUEST) && (rdCnt > 0 || wrCnt > 0)) protoErr++;
      if (oREAD_REQUEST && oWRITE_REQUEST) protoErr++;
      if (rdCnt > 0) begin
        if (o_addr !== pendRdAddr) protoErr++;
        rdCnt--;
        if (rdCnt == 0) begin
          iDATA_FROM_FLASH = flashMem[pendRdAddr[12:0]];
          iDATA_READY = 1'b1;
        end
      end
      if (wrCnt > 0) begin
        if (o_addr !== pendWrAddr || oDATA_TO_FLASH !== pendWrData) protoErr++;
        wrCnt--;
        if (wrCnt == 0) iWrite_Done = 1'b1;
      end
      if (oREAD_REQUEST) begin
        pendRdAddr = o_addr;
        rdAddrLog.push_back(int'(o_addr));
        rdTime.push_back($time);
        rdCnt = 1 + flashLat;
      end
      if (oWRITE_REQUEST) begin
        pendWrAddr = o_addr;
        pendWrData = oDATA_TO_FLASH;
        flashMem[o_addr[12:0]] = oDATA_TO_FLASH;
        wrAddrLog.push_back(int'(o_addr));
        wrDataLog.push_back(int'(oDATA_TO_FLASH));
        wrTime.push_back($time);
        wrCnt = 1 + flashLat;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_ctrl"}, int'({oBusy, oFinish, oPOS_ACK, oREAD_REQUEST, oWRITE_REQUEST}), 0);
    check({tag, "_data"}, int'(oDATA_TO_FLASH), 0);
    check({tag, "_addr"}, int'(o_addr), 0);
    check({tag, "_dropped"}, int'(oDropped), 0);
  endtask

  task automatic doReset();
    iRST = 1'b0;
    iPOS_VALID = 1'b0;
    iStart = 1'b0;
    iFlush = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic doStart();
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    check("busy_after_start", int'(oBusy), 1);
  endtask

  task automatic doFlush();
    bit fin;
    fin = 1'b0;
    iFlush = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge iCLK);
      iFlush = 1'b0;
      if (oFinish) begin
        fin = 1'b1;
        break;
      end
    end
    check("flush_finish", int'(fin), 1);
    check("busy_after_flush", int'(oBusy), 0);
  endtask

  task automatic sendSample(input int x, input int y, input bit down,
                            output int lat, output bit acked);
    iX = 9'(x);
    iY = 9'(y);
    iDown = down;
    iPOS_VALID = 1'b1;
    acked = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge iCLK);
      lat++;
      if (oPOS_ACK) begin
        acked = 1'b1;
        break;
      end
    end
    iPOS_VALID = 1'b0;
    @(negedge iCLK);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int x;
    int y;
    bit down;
    int expLat;   // 0 = not checked
    int expRd;    // number of reads caused
    int expWr;    // number of writes caused
    int rdAddr;   // -1 = none
    int wrAddr;   // -1 = none
    int wrData;
  } vec_t;

  vec_t vecs[9];

  logic [15:0] refMem [0:8191] = '{default: 16'h0000};

  initial begin : main
    int lat;
    bit acked;
    int rd0, wr0;
    longint ackT, finT;
    bit sawReq;
    int acks;
    bit fin;
    int refDropped;
    int lastWord;
    bit lastValid;
    int diffs;

    vecs[0] = '{0,   0,   1'b1, 0, 1, 0, 0,  -1, 0};
    vecs[1] = '{17,  1,   1'b1, 0, 1, 1, 25, 0,  'h8000};
    vecs[2] = '{31,  1,   1'b1, 1, 0, 0, -1, -1, 0};
    vecs[3] = '{384, 5,   1'b1, 1, 0, 0, -1, -1, 0};
    vecs[4] = '{3,   288, 1'b1, 1, 0, 0, -1, -1, 0};
    vecs[5] = '{5,   5,   1'b0, 1, 0, 0, -1, -1, 0};
    vecs[6] = '{0,   1,   1'b1, 0, 1, 1, 24, 25, 'h4001};
    vecs[7] = '{0,   0,   1'b1, 0, 1, 1, 0,  24, 'h8000};
    vecs[8] = '{0,   1,   1'b1, 0, 1, 1, 24, 0,  'h8000};

    // reset values
    doReset();
    checkResetOutputs("reset");

    // single pixel at origin, written back by flush
    doStart();
    rd0 = rdAddrLog.size();
    wr0 = wrAddrLog.size();
    sendSample(0, 0, 1'b1, lat, acked);
    check("origin_ack", int'(acked), 1);
    check("origin_no_early_write", wrAddrLog.size() - wr0, 0);
    doFlush();
    check("origin_reads", rdAddrLog.size() - rd0, 1);
    check("origin_writes", wrAddrLog.size() - wr0, 1);
    if (wrAddrLog.size() > wr0) begin
      check("origin_wr_addr", wrAddrLog[wr0], 0);
      check("origin_wr_data", wrDataLog[wr0], 'h8000);
    end

    // table-driven sequence
    doStart();
    for (int v = 0; v < 9; v++) begin
      rd0 = rdAddrLog.size();
      wr0 = wrAddrLog.size();
      flashLat = v % 3;
      sendSample(vecs[v].x, vecs[v].y, vecs[v].down, lat, acked);
      check($sformatf("vec%0d_ack", v), int'(acked), 1);
      if (vecs[v].expLat > 0) check($sformatf("vec%0d_lat", v), lat, vecs[v].expLat);
      check($sformatf("vec%0d_reads", v), rdAddrLog.size() - rd0, vecs[v].expRd);
      check($sformatf("vec%0d_writes", v), wrAddrLog.size() - wr0, vecs[v].expWr);
      if (vecs[v].rdAddr >= 0 && rdAddrLog.size() > rd0)
        check($sformatf("vec%0d_rd_addr", v), rdAddrLog[rd0], vecs[v].rdAddr);
      if (vecs[v].wrAddr >= 0 && wrAddrLog.size() > wr0) begin
        check($sformatf("vec%0d_wr_addr", v), wrAddrLog[wr0], vecs[v].wrAddr);
        check($sformatf("vec%0d_wr_data", v), wrDataLog[wr0], vecs[v].wrData);
        if (rdTime.size() > rd0)
          check($sformatf("vec%0d_wr_before_rd", v), int'(wrTime[wr0] < rdTime[rd0]), 1);
      end
    end
    check("table_dropped", int'(oDropped), 2);
    wr0 = wrAddrLog.size();
    doFlush();
    check("table_flush_writes", wrAddrLog.size() - wr0, 1);
    if (wrAddrLog.size() > wr0) begin
      check("table_flush_addr", wrAddrLog[wr0], 24);
      check("table_flush_data", wrDataLog[wr0], 'h8000);
    end

    // pen-up only: 1-cycle acks, no flash traffic
    flashLat = 0;
    doStart();
    rd0 = rdAddrLog.size();
    wr0 = wrAddrLog.size();
    for (int i = 0; i < 3; i++) begin
      sendSample(i * 50, i * 40, 1'b0, lat, acked);
      check($sformatf("penup%0d_lat", i), acked ? lat : -1, 1);
    end
    doFlush();
    check("penup_traffic", (rdAddrLog.size() - rd0) + (wrAddrLog.size() - wr0), 0);

    // flush raised while the read is outstanding
    flashLat = 3;
    doStart();
    rd0 = rdAddrLog.size();
    wr0 = wrAddrLog.size();
    iX = 9'd40;
    iY = 9'd7;
    iDown = 1'b1;
    iPOS_VALID = 1'b1;
    sawReq = 1'b0;
    ackT = -1;
    finT = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge iCLK);
      iFlush = 1'b0;
      if (oREAD_REQUEST && !sawReq) begin
        sawReq = 1'b1;
        iFlush = 1'b1;
      end
      if (oPOS_ACK && ackT < 0) begin
        ackT = $time;
        iPOS_VALID = 1'b0;
      end
      if (oFinish) begin
        finT = $time;
        break;
      end
    end
    iFlush = 1'b0;
    iPOS_VALID = 1'b0;
    check("rdflush_acked", int'(ackT >= 0), 1);
    check("rdflush_finished", int'(finT >= 0), 1);
    check("rdflush_writes", wrAddrLog.size() - wr0, 1);
    if (wrAddrLog.size() > wr0) begin
      check("rdflush_wr_addr", wrAddrLog[wr0], 7 * 24 + 2);
      check("rdflush_wr_data", wrDataLog[wr0], 'h0080);
      check("rdflush_order", int'(ackT >= 0 && ackT < wrTime[wr0] && wrTime[wr0] < finT), 1);
    end
    check("rdflush_busy", int'(oBusy), 0);
    @(negedge iCLK);

    // simultaneous flush and sample: flush wins, sample not acked (and
    // stays unacked once the block is back in IDLE)
    flashLat = 0;
    doStart();
    iX = 9'd1;
    iY = 9'd1;
    iDown = 1'b1;
    iPOS_VALID = 1'b1;
    iFlush = 1'b1;
    acks = 0;
    fin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge iCLK);
      iFlush = 1'b0;
      if (oPOS_ACK) acks++;
      if (oFinish) fin = 1'b1;
    end
    iPOS_VALID = 1'b0;
    check("sim_flush_finish", int'(fin), 1);
    check("sim_flush_no_ack", acks, 0);
    @(negedge iCLK);

    // reset while waiting for a write-back
    flashLat = 8;
    doStart();
    sendSample(400, 0, 1'b1, lat, acked);
    sendSample(0, 0, 1'b1, lat, acked);
    check("midwb_first_ack", int'(acked), 1);
    iX = 9'd16;
    iY = 9'd0;
    iDown = 1'b1;
    iPOS_VALID = 1'b1;
    sawReq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      if (oWRITE_REQUEST) begin
        sawReq = 1'b1;
        break;
      end
    end
    check("midwb_wr_req_seen", int'(sawReq), 1);
    @(negedge iCLK);
    iRST = 1'b0;
    iPOS_VALID = 1'b0;
    @(negedge iCLK);
    checkResetOutputs("midwb");
    iRST = 1'b1;
    @(negedge iCLK);

    // randomized samples against the pixel-level reference bitmap
    for (int w = 0; w < 8192; w++) refMem[w] = flashMem[w];
    doStart();
    refDropped = 0;
    lastValid = 1'b0;
    lastWord = 0;
    for (int k = 0; k < 80; k++) begin
      int x, y, idx, word;
      bit down;
      x = $urandom_range(0, 400);
      y = $urandom_range(0, 300);
      down = ($urandom_range(0, 3) != 0);
      flashLat = $urandom_range(0, 3);
      sendSample(x, y, down, lat, acked);
      check("rand_ack", int'(acked), 1);
      if (!down) begin
        check("rand_up_lat", lat, 1);
      end else if (x >= 384 || y >= 288) begin
        check("rand_drop_lat", lat, 1);
        refDropped++;
      end else begin
        idx = y * 384 + x;
        word = idx / 16;
        refMem[word] = refMem[word] | 16'(1 << (15 - (idx % 16)));
        if (lastValid && word == lastWord) check("rand_hit_lat", lat, 1);
        else check("rand_miss_slow", int'(lat > 1), 1);
        lastWord = word;
        lastValid = 1'b1;
      end
      if (k % 20 == 19) begin
        check("rand_dropped", int'(oDropped), refDropped);
        doFlush();
        diffs = 0;
        for (int w = 0; w < 8192; w++) if (flashMem[w] !== refMem[w]) diffs++;
        check("rand_bitmap", diffs, 0);
        doStart();
        refDropped = 0;
        lastValid = 1'b0;
      end
    end
    doFlush();

    check("flash_protocol", protoErr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

endmodule
